dff_bank_arbiter: RTL
=====================

DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

Interface
REQ-001 Parameter: WIDTH, default 6, data width of the shared register bank.
REQ-002 Parameter: MAX_HOLD, default 4, maximum consecutive grant cycles when the other requester waits (legal range 1..15).
REQ-003 Port: clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req_a  input  1  requester A wants bank write access.
REQ-006 Port: data_a  input  WIDTH  requester A write data.
REQ-007 Port: req_b  input  1  requester B wants bank write access.
REQ-008 Port: data_b  input  WIDTH  requester B write data.
REQ-009 Port: clr  input  1  synchronous clear of bank contents.
REQ-010 Port: gnt_a  output  1  registered grant to A.
REQ-011 Port: gnt_b  output  1  registered grant to B.
REQ-012 Port: q  output  WIDTH  registered bank contents.
REQ-013 Port: q_valid  output  1  bank holds data written since last clear/reset.
REQ-014 Port: owner  output  1  last granted requester (0 = A, 1 = B).

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, GRANT_A, GRANT_B; gnt_a = (state==GRANT_A), gnt_b = (state==GRANT_B), both driven from flops, never high together.
REQ-016 IDLE: req_a only -> GRANT_A; req_b only -> GRANT_B; both -> requester not equal to owner; neither -> IDLE.
REQ-017 Grant latency SHALL be one cycle: request sampled at edge n -> grant high after edge n.
REQ-018 Bank write: at an edge where state==GRANT_X and req_X==1, q <= data_X and q_valid <= 1; no write in any other case.
REQ-019 A 4-bit hold counter SHALL increment on each write, reset to 0 on every state change, and saturate at MAX_HOLD-1.
REQ-020 GRANT_X with req_X==1: if hold counter == MAX_HOLD-1 and the other requester is high, the write SHALL occur and state SHALL move directly to the other GRANT (no IDLE cycle); otherwise stay in GRANT_X.
REQ-021 GRANT_X with req_X==0: no write; next state is the other GRANT if the other requester is high, else IDLE.
REQ-022 owner SHALL update to the newly granted requester on every entry into GRANT_A/GRANT_B and hold otherwise.
REQ-023 clr==1 at an edge SHALL force q <= 0 and q_valid <= 0, overriding any same-edge write; FSM, counter, owner unaffected.
REQ-024 MAX_HOLD==1 SHALL alternate grants every cycle while both requesters stay high.
REQ-025 A requester deasserting while granted SHALL lose the grant at the next edge; no write occurs at that edge.

Reset
REQ-026 reset high SHALL immediately (without clk) force state IDLE, gnt_a=0, gnt_b=0, q=0, q_valid=0, hold counter 0, owner=1 (so A wins the first tie).
REQ-027 reset asserted mid-grant SHALL abort the grant with no further write; after release, arbitration restarts from IDLE on the next edge.
REQ-028 reset deassertion SHALL be synchronized externally; the block adds no synchronizer.

Verification
REQ-029 After reset, req_a=req_b=1 at same edge, data_a=0x15, data_b=0x2A -> gnt_a after edge 1; q=0x15, q_valid=1 after edge 2; owner=0.
REQ-030 Both requests held, MAX_HOLD=4 -> gnt_a for 4 cycles (4 writes of data_a), gnt_b the next 4 cycles, alternating with no idle gap.
REQ-031 req_a alone held 10 cycles -> gnt_a stays high throughout (no forced release), 9 writes counted, no gnt_b.
REQ-032 In GRANT_B with data_b=0x3F, clr=1 on a write edge -> q=0x00, q_valid=0 after that edge; gnt_b still high; next edge q=0x3F.
REQ-033 req_b drops while granted, req_a low -> next edge IDLE, both grants 0, q unchanged.
REQ-034 reset pulsed between clock edges during GRANT_A -> gnt_a, q, q_valid fall to 0 before the next edge; owner=1.

Source files
------------

// File: rtl/dff_bank_arbiter_if.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter_if
//
// Purpose : Bundles the signals between two requesters and the shared
//           register bank arbiter (dff_bank_arbiter).
//
// Signals :
//   req_a, data_a  requester A write request and data
//   req_b, data_b  requester B write request and data
//   clr            synchronous clear of the bank contents
//   gnt_a, gnt_b   registered grants, never high together
//   q              registered bank contents
//   q_valid        bank holds data written since the last clear/reset
//   owner          last granted requester (0 = A, 1 = B)
//
// Modports:
//   master  requester side (drives requests/data/clr, observes results)
//   slave   arbiter side   (observes requests/data/clr, drives results)
// -----------------------------------------------------------------------------
interface dff_bank_arbiter_if #(
    parameter int WIDTH = 6
);

    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             clr;
    logic             gnt_a;
    logic             gnt_b;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             owner;

    modport master (
        output req_a, data_a, req_b, data_b, clr,
        input  gnt_a, gnt_b, q, q_valid, owner
    );

    modport slave (
        input  req_a, data_a, req_b, data_b, clr,
        output gnt_a, gnt_b, q, q_valid, owner
    );

endinterface

// File: rtl/dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter
//
// Purpose : Two-requester arbiter guarding a single WIDTH-bit register bank.
//           A granted requester writes its data on every cycle it keeps its
//           request high. When both requesters compete, a grant lasts at most
//           MAX_HOLD write cycles before it passes directly to the other
//           requester; ties from IDLE go to the requester that did not own
//           the bank last.
//
// Parameters:
//   WIDTH     data width of the bank (default 6)
//   MAX_HOLD  maximum consecutive write cycles while the other side waits,
//             legal range 1..15 (default 4)
//
// Ports:
//   clk    sole clock, all state changes on its rising edge
//   reset  asynchronous, active-high reset; deassertion must already be
//          synchronous to clk (no synchronizer inside)
//   bus    dff_bank_arbiter_if.slave: req_a/data_a, req_b/data_b, clr in;
//          gnt_a, gnt_b, q, q_valid, owner out
// -----------------------------------------------------------------------------
module dff_bank_arbiter #(
    parameter int WIDTH    = 6,
    parameter int MAX_HOLD = 4
) (
    input logic               clk,
    input logic               reset,
    dff_bank_arbiter_if.slave bus
);

    // Encoding chosen so each grant is a state flop bit on its own.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } state_t;

    // Last value of the 4-bit hold counter; reaching it ends a contested grant.
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       hold_cnt;
    logic             hold_expired;
    logic             state_change;
    logic             owner_q;
    logic [WIDTH-1:0] bank_q;
    logic             bank_valid_q;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;

    assign hold_expired = (hold_cnt == HOLD_LAST);
    assign state_change = (state_nxt != state);

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.req_a && bus.req_b) begin
                    // Tie: the requester that did not own the bank last wins.
                    state_nxt = owner_q ? GRANT_A : GRANT_B;
                end else if (bus.req_a) begin
                    state_nxt = GRANT_A;
                end else if (bus.req_b) begin
                    state_nxt = GRANT_B;
                end
            end
            GRANT_A: begin
                if (bus.req_a) begin
                    // The write still happens on the hand-over edge.
                    if (hold_expired && bus.req_b) begin
                        state_nxt = GRANT_B;
                    end
                end else begin
                    state_nxt = bus.req_b ? GRANT_B : IDLE;
                end
            end
            GRANT_B: begin
                if (bus.req_b) begin
                    if (hold_expired && bus.req_a) begin
                        state_nxt = GRANT_A;
                    end
                end else begin
                    state_nxt = bus.req_a ? GRANT_A : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs decoded from the current state
    // -------------------------------------------------------------------------
    // Grants come straight from state flop bits; the write strobe is only
    // asserted while the current grant holder keeps requesting.
    always_comb begin
        bus.gnt_a = state[0];
        bus.gnt_b = state[1];
        wr_en     = 1'b0;
        wr_data   = bus.data_a;
        unique case (state)
            GRANT_A: begin
                wr_en   = bus.req_a;
                wr_data = bus.data_a;
            end
            GRANT_B: begin
                wr_en   = bus.req_b;
                wr_data = bus.data_b;
            end
            default: begin
                wr_en   = 1'b0;
                wr_data = bus.data_a;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Hold counter: counts writes within one grant, saturating at HOLD_LAST.
    // A state change takes priority so each new grant starts from zero, even
    // when the hand-over edge itself carries a write.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= 4'd0;
        end else if (state_change) begin
            hold_cnt <= 4'd0;
        end else if (wr_en && !hold_expired) begin
            hold_cnt <= hold_cnt + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Owner: tracks the most recently granted requester. Reset value 1 makes
    // requester A win the first tie after reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= 1'b1;
        end else if (state_change && (state_nxt != IDLE)) begin
            owner_q <= (state_nxt == GRANT_B);
        end
    end

    // -------------------------------------------------------------------------
    // Shared bank. clr wins over a same-edge write and leaves the arbitration
    // state alone.
    // -------------------------------------------------------------------------
    // NOTE: the bank is a plain register, not a memory array, and its value is
    // architecturally visible immediately after reset, so it is reset too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q       <= '0;
            bank_valid_q <= 1'b0;
        end else if (bus.clr) begin
            bank_q       <= '0;
            bank_valid_q <= 1'b0;
        end else if (wr_en) begin
            bank_q       <= wr_data;
            bank_valid_q <= 1'b1;
        end
    end

    assign bus.q       = bank_q;
    assign bus.q_valid = bank_valid_q;
    assign bus.owner   = owner_q;

    // -------------------------------------------------------------------------
    // Design invariants
    // -------------------------------------------------------------------------
    a_grants_exclusive : assert property (
        @(posedge clk) disable iff (reset) !(bus.gnt_a && bus.gnt_b)
    );

    a_hold_in_range : assert property (
        @(posedge clk) disable iff (reset) (hold_cnt <= HOLD_LAST)
    );

    a_idle_count_zero : assert property (
        @(posedge clk) disable iff (reset) (state == IDLE) |-> (hold_cnt == 4'd0)
    );

endmodule
